// File: rtl/mem_stage_ctrl.sv
// Memory-stage front end for the direct-mapped cache: one request per instruction, stall, timeout, perf counters.
// Optional build macro MEM_ALIGN_CHECK_EN: reject odd-address requests in IDLE with an error pulse.
//
// state | meaning
// IDLE  | waiting for a load/store from the memory stage
// REQ   | one-cycle read/write strobe to the cache controller
// WAIT  | waiting for fs_done / fs_err, timeout counter running
// DONE  | result valid, pipeline released for one cycle
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] p_addr,
    input  logic [15:0] p_data_in,
    input  logic        p_rd,
    input  logic        p_wr,
    output logic [15:0] p_data_out,
    output logic        p_stall,
    output logic        p_hit,
    output logic        p_err,
    output logic [15:0] c_addr,
    output logic [15:0] c_data_in,
    output logic        c_read,
    output logic        c_write,
    input  logic [15:0] fs_data_out,
    input  logic        fs_done,
    input  logic        fs_cachehit,
    input  logic        fs_err,
    output logic [15:0] acc_cnt,
    output logic [15:0] hit_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] addr_q, data_q, dout_q, acc_q, hitc_q;
    logic        op_wr_q, hit_q;
    logic [5:0]  tmo_q;
    logic        misalign, accept, finish, tmo_hit;

    assign c_addr     = addr_q;
    assign c_data_in  = data_q;
    assign p_data_out = dout_q;
    assign p_hit      = hit_q;
    assign acc_cnt    = acc_q;
    assign hit_cnt    = hitc_q;
    assign tmo_hit    = (tmo_q == TMO_LAST);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = p_addr[0];
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        p_stall = 1'b0;
        p_err   = 1'b0;
        c_read  = 1'b0;
        c_write = 1'b0;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (p_rd && p_wr) begin
                    p_err = 1'b1;
                end else if (p_rd ^ p_wr) begin
                    if (misalign) begin
                        p_err = 1'b1;
                    end else begin
                        p_stall = 1'b1;
                        accept  = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                p_stall = 1'b1;
                c_read  = ~op_wr_q;
                c_write = op_wr_q;
                state_d = WAIT;
            end
            WAIT: begin
                // error aborts take priority over completion; stall drops so the pipeline sees p_err
                if (fs_err) begin
                    p_err   = 1'b1;
                    state_d = IDLE;
                end else if (fs_done) begin
                    p_stall = 1'b1;
                    finish  = 1'b1;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    p_err   = 1'b1;
                    state_d = IDLE;
                end else begin
                    p_stall = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            data_q  <= 16'h0000;
            op_wr_q <= 1'b0;
            tmo_q   <= 6'd0;
            dout_q  <= 16'h0000;
            hit_q   <= 1'b0;
            acc_q   <= 16'h0000;
            hitc_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= p_addr;
                data_q  <= p_data_in;
                op_wr_q <= p_wr;
            end
            if (state_q == REQ) begin
                tmo_q <= 6'd0;
            end else if (state_q == WAIT && !fs_err && !fs_done && !tmo_hit) begin
                tmo_q <= tmo_q + 6'd1;
            end
            // counters advance on entry to DONE so they read updated during the DONE cycle
            if (finish) begin
                if (!op_wr_q) begin
                    dout_q <= fs_data_out;
                end
                hit_q <= fs_cachehit;
                if (acc_q != 16'hFFFF) begin
                    acc_q <= acc_q + 16'd1;
                end
                if (fs_cachehit && hitc_q != 16'hFFFF) begin
                    hitc_q <= hitc_q + 16'd1;
                end
            end
        end
    end

endmodule
